// File: rtl/seq_age_buffer_if.sv
// Commit notification: one pulse per retired sequence number, advancing the age head.
interface CommitNotif;
    logic val;

    modport pub (output val);
    modport sub (input val);
endinterface

// File: rtl/seq_age_buffer.sv
// Age-ordered holding buffer: accepts the oldest producer request and always presents the
// oldest stored entry. Optional squash ports are enabled by defining SEQ_AGE_BUFFER_SQUASH_EN.
module seq_age_buffer #(
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_num_arb      = 4,
    parameter int unsigned p_depth        = 4,
    parameter int unsigned p_data_bits    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [p_num_arb-1:0][p_seq_num_bits-1:0]  enq_seq_num,
    input  logic [p_num_arb-1:0][p_data_bits-1:0]     enq_data,
    input  logic [p_num_arb-1:0]                      enq_val,
    output logic [p_num_arb-1:0]                      enq_rdy,
    output logic [p_seq_num_bits-1:0]                 deq_seq_num,
    output logic [p_data_bits-1:0]                    deq_data,
    output logic                                      deq_val,
    input  logic                                      deq_rdy,
    output logic [$clog2(p_depth+1)-1:0]              count,
`ifdef SEQ_AGE_BUFFER_SQUASH_EN
    input  logic                                      squash_val,
    input  logic [p_seq_num_bits-1:0]                 squash_seq_num,
`endif
    CommitNotif.sub                                   commit
);
    localparam int unsigned SW = p_seq_num_bits;
    localparam int unsigned DW = p_data_bits;
    localparam int unsigned CW = $clog2(p_depth + 1);

    typedef logic [SW-1:0] seq_t;

    seq_t                        head;
    logic [p_depth-1:0]          slot_val;
    logic [p_depth-1:0][SW-1:0]  slot_tag;
    logic [p_depth-1:0][DW-1:0]  slot_data;

    logic [p_num_arb-1:0] enq_sel;
    logic                 enq_found;
    seq_t                 enq_age;
    seq_t                 enq_tag;
    logic [DW-1:0]        enq_dat;
    logic                 enq_fire;

    logic [p_depth-1:0]   deq_sel;
    logic                 deq_found;
    seq_t                 deq_age;
    logic                 deq_fire;

    logic [p_depth-1:0]   free_sel;
    logic                 free_found;
    logic [CW-1:0]        occ;
    logic                 full;

    logic                 sq_val;
    seq_t                 sq_tag;
    logic                 sq_block;
    logic [p_depth-1:0]   sq_kill;

    // Distance from the head; wraps mod 2^SW so a smaller value means older.
    function automatic seq_t age_of(input seq_t x, input seq_t base);
        return x - base;
    endfunction

`ifdef SEQ_AGE_BUFFER_SQUASH_EN
    assign sq_val = squash_val;
    assign sq_tag = squash_seq_num;
`else
    assign sq_val = 1'b0;
    assign sq_tag = '0;
`endif

    // Oldest requesting channel; strict compare keeps the lowest index on equal age.
    always_comb begin
        enq_sel   = '0;
        enq_found = 1'b0;
        enq_age   = '0;
        enq_tag   = '0;
        enq_dat   = '0;
        for (int i = 0; i < int'(p_num_arb); i++) begin
            if (enq_val[i] && (!enq_found || (age_of(enq_seq_num[i], head) < enq_age))) begin
                enq_found  = 1'b1;
                enq_age    = age_of(enq_seq_num[i], head);
                enq_tag    = enq_seq_num[i];
                enq_dat    = enq_data[i];
                enq_sel    = '0;
                enq_sel[i] = 1'b1;
            end
        end
    end

    // Oldest valid slot drives the dequeue port.
    always_comb begin
        deq_sel     = '0;
        deq_found   = 1'b0;
        deq_age     = '0;
        deq_seq_num = '0;
        deq_data    = '0;
        for (int i = 0; i < int'(p_depth); i++) begin
            if (slot_val[i] && (!deq_found || (age_of(slot_tag[i], head) < deq_age))) begin
                deq_found   = 1'b1;
                deq_age     = age_of(slot_tag[i], head);
                deq_seq_num = slot_tag[i];
                deq_data    = slot_data[i];
                deq_sel     = '0;
                deq_sel[i]  = 1'b1;
            end
        end
    end

    // Lowest free slot, occupancy and squash victims.
    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        occ        = '0;
        sq_kill    = '0;
        for (int i = 0; i < int'(p_depth); i++) begin
            if (!slot_val[i] && !free_found) begin
                free_found  = 1'b1;
                free_sel[i] = 1'b1;
            end
            occ        = occ + CW'(slot_val[i]);
            sq_kill[i] = sq_val && (age_of(slot_tag[i], head) > age_of(sq_tag, head));
        end
    end

    assign full     = (occ == CW'(p_depth));
    assign sq_block = sq_val && (age_of(enq_tag, head) > age_of(sq_tag, head));
    assign enq_rdy  = (enq_found && !full && !sq_block) ? enq_sel : '0;
    assign enq_fire = |enq_rdy;
    assign deq_val  = deq_found;
    assign deq_fire = deq_found && deq_rdy;
    assign count    = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            slot_val <= '0;
        end else begin
            if (commit.val) begin
                head <= head + SW'(1);
            end
            slot_val <= (slot_val & ~(deq_sel & {p_depth{deq_fire}}) & ~sq_kill)
                      | (free_sel & {p_depth{enq_fire}});
        end
    end

    // Payload storage carries no reset; validity lives in slot_val.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(p_depth); i++) begin
            if (enq_fire && free_sel[i]) begin
                slot_tag[i]  <= enq_tag;
                slot_data[i] <= enq_dat;
            end
        end
    end

endmodule
